// File: rtl/adder_pipe.sv
// ============================================================================
//  Module   : adder_pipe
//  Brief    : Pipelined add/subtract unit, one carry-chain chunk per stage,
//             wrap or signed-saturating modes, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_a_in,
  input  logic [DATA_WIDTH-1:0] data_b_in,
  input  logic [1:0]            op_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  carry_out,
  output logic                  overflow_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam int STAGES = DATA_WIDTH / CHUNK_WIDTH;
  localparam int MSB    = DATA_WIDTH - 1;

  localparam logic [DATA_WIDTH-1:0] c_sat_pos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_sat_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Per-stage state: operands (B already conditioned for sub), partial sum,
  // carry into the next chunk and the saturate-mode bit.
  logic [STAGES-1:0]     r_valid;
  logic [STAGES-1:0]     r_carry;
  logic [STAGES-1:0]     r_sat;
  logic [DATA_WIDTH-1:0] r_a   [STAGES];
  logic [DATA_WIDTH-1:0] r_b   [STAGES];
  logic [DATA_WIDTH-1:0] r_sum [STAGES];

  logic [STAGES-1:0]     w_free;
  logic [STAGES-1:0]     w_valid_src;
  logic [STAGES-1:0]     w_cin;
  logic [STAGES-1:0]     w_sat_src;
  logic [STAGES-1:0]     w_carry_nxt;
  logic [DATA_WIDTH-1:0] w_a_src   [STAGES];
  logic [DATA_WIDTH-1:0] w_b_src   [STAGES];
  logic [DATA_WIDTH-1:0] w_sum_src [STAGES];
  logic [DATA_WIDTH-1:0] w_sum_nxt [STAGES];
  logic [CHUNK_WIDTH:0]  w_chunk   [STAGES];

  logic [DATA_WIDTH-1:0] w_last_sum;
  logic                  w_a_msb;
  logic                  w_b_msb;
  logic                  w_ovf;

  // A stage can take a new entry when it is empty or its occupant moves on.
  always_comb begin
    w_free[STAGES-1] = !r_valid[STAGES-1] || ready_in;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_free[k] = !r_valid[k] || w_free[k+1];
    end
  end

  assign ready_out = w_free[0];

  // Stage sources: stage 0 from the ports, later stages from the previous register.
  always_comb begin
    w_valid_src[0] = valid_in;
    w_a_src[0]     = data_a_in;
    w_b_src[0]     = op_in[0] ? ~data_b_in : data_b_in;
    w_sum_src[0]   = '0;
    w_cin[0]       = op_in[0];
    w_sat_src[0]   = op_in[1];
    for (int k = 1; k < STAGES; k++) begin
      w_valid_src[k] = r_valid[k-1];
      w_a_src[k]     = r_a[k-1];
      w_b_src[k]     = r_b[k-1];
      w_sum_src[k]   = r_sum[k-1];
      w_cin[k]       = r_carry[k-1];
      w_sat_src[k]   = r_sat[k-1];
    end
  end

  // One chunk of the carry chain per stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_a_src[k][k*CHUNK_WIDTH +: CHUNK_WIDTH]}
                 + {1'b0, w_b_src[k][k*CHUNK_WIDTH +: CHUNK_WIDTH]}
                 + {{CHUNK_WIDTH{1'b0}}, w_cin[k]};
      w_sum_nxt[k] = w_sum_src[k];
      w_sum_nxt[k][k*CHUNK_WIDTH +: CHUNK_WIDTH] = w_chunk[k][CHUNK_WIDTH-1:0];
      w_carry_nxt[k] = w_chunk[k][CHUNK_WIDTH];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
      r_carry <= '0;
      r_sat   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_free[k]) begin
          r_valid[k] <= w_valid_src[k];
          // Payload only moves with a real entry so a stalled output never twitches.
          if (w_valid_src[k]) begin
            r_a[k]     <= w_a_src[k];
            r_b[k]     <= w_b_src[k];
            r_sum[k]   <= w_sum_nxt[k];
            r_carry[k] <= w_carry_nxt[k];
            r_sat[k]   <= w_sat_src[k];
          end
        end
      end
    end
  end

  // Flags from the full unsaturated sum; saturation only substitutes the data.
  assign w_last_sum = r_sum[STAGES-1];
  assign w_a_msb    = r_a[STAGES-1][MSB];
  assign w_b_msb    = r_b[STAGES-1][MSB];
  assign w_ovf      = (w_a_msb == w_b_msb) && (w_last_sum[MSB] != w_a_msb);

  always_comb begin
    data_out = w_last_sum;
    if (r_sat[STAGES-1] && w_ovf) begin
      data_out = w_a_msb ? c_sat_neg : c_sat_pos;
    end
  end

  assign carry_out    = r_carry[STAGES-1];
  assign overflow_out = w_ovf;
  assign valid_out    = r_valid[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_adder_pipe.sv
// ============================================================================
//  Module   : tb_adder_pipe
//  Brief    : Scoreboard bench for adder_pipe (16-bit, 4-bit chunks).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_pipe;

  localparam int DW     = 16;
  localparam int CW     = 4;
  localparam int STAGES = DW / CW;

  logic          clk_in    = 1'b0;
  logic          rst_in    = 1'b0;
  logic [DW-1:0] data_a_in = '0;
  logic [DW-1:0] data_b_in = '0;
  logic [1:0]    op_in     = '0;
  logic          valid_in  = 1'b0;
  logic          ready_in  = 1'b0;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          carry_out;
  logic          overflow_out;
  logic          valid_out;

  adder_pipe #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_a_in    (data_a_in),
    .data_b_in    (data_b_in),
    .op_in        (op_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] sb [$];
  int          occ      = 0;
  logic        stalled  = 1'b0;
  logic [17:0] held     = '0;
  logic        saw_full = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-word reference: {result, carry, overflow}.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    logic [15:0] res;
    bb   = op[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, op[0]};
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    res  = full[15:0];
    if (op[1] && ovf) res = a[15] ? 16'h8000 : 16'h7FFF;
    return {res, full[16], ovf};
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: transfers happen at the next rising edge; inputs are stable here.
  always @(negedge clk_in) begin : monitor
    logic        emit;
    logic        acc;
    logic [17:0] exp;
    if (rst_in) begin
      sb.delete();
      occ     = 0;
      stalled = 1'b0;
    end else begin
      emit = valid_out && ready_in;
      acc  = valid_in && ready_out;
      check_value("ready_out", 32'(ready_out), 32'((occ != STAGES) || emit));
      if (!ready_out) saw_full = 1'b1;
      if (stalled) begin
        check_value("stall_hold", 32'({valid_out, data_out, carry_out, overflow_out}),
                    32'({1'b1, held}));
      end
      if (emit) begin
        if (sb.size() == 0) begin
          check_value("unexpected_out", 32'({data_out, carry_out, overflow_out}), 32'hDEAD_BEEF);
        end else begin
          exp = sb.pop_front();
          check_value("result", 32'({data_out, carry_out, overflow_out}), 32'(exp));
        end
      end
      if (acc) sb.push_back(ref_model(data_a_in, data_b_in, op_in));
      occ     = occ + int'(acc) - int'(emit);
      stalled = valid_out && !ready_in;
      held    = {data_out, carry_out, overflow_out};
    end
  end

  // One op into an empty pipe; latency counts rising edges including the accepting one.
  task automatic send_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] ed, input logic ec,
                         input logic ev);
    int lat;
    @(posedge clk_in) #1;
    data_a_in = a; data_b_in = b; op_in = op; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk_in);
    check_value({tag, "_accept"}, 32'(ready_out), 32'd1);
    @(posedge clk_in) #1;
    valid_in  = 1'b0;
    data_a_in = 16'hA5A5; data_b_in = 16'h5A5A; op_in = ~op;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk_in) #1;
      lat++;
    end
    check_value({tag, "_latency"}, 32'(lat), 32'(STAGES));
    check_value({tag, "_data"}, 32'(data_out), 32'(ed));
    check_value({tag, "_carry"}, 32'(carry_out), 32'(ec));
    check_value({tag, "_ovf"}, 32'(overflow_out), 32'(ev));
    @(posedge clk_in) #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int i;
    int t;
    int n_acc;
    int cyc;
    int cnt;
    logic acc;

    // Reset values
    #1 rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_value("rst_valid", 32'(valid_out), 32'd0);
    check_value("rst_data", 32'(data_out), 32'd0);
    check_value("rst_flags", 32'({carry_out, overflow_out}), 32'd0);
    rst_in = 1'b0;
    #1;
    check_value("rst_ready", 32'(ready_out), 32'd1);

    // Directed vectors, including full-length ripple and saturation corners
    send_op("add_basic", 16'h1234, 16'h0FFF, 2'b00, 16'h2233, 1'b0, 1'b0);
    send_op("add_wrap",  16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0);
    send_op("sub_wrap",  16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b0);
    send_op("add_ripple",16'h0FFF, 16'h0001, 2'b00, 16'h1000, 1'b0, 1'b0);
    send_op("add_sat",   16'h7FFF, 16'h0001, 2'b10, 16'h7FFF, 1'b0, 1'b1);
    send_op("sub_sat",   16'h8000, 16'h0001, 2'b11, 16'h8000, 1'b1, 1'b1);
    send_op("addw_ovf",  16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1);
    send_op("sub_nob",   16'h0005, 16'h0003, 2'b01, 16'h0002, 1'b1, 1'b0);

    // 8 back-to-back ops with the consumer stalled in cycles 3..6
    saw_full = 1'b0;
    i = 0; t = 0;
    while ((i < 8 || sb.size() != 0) && t < 100) begin
      ready_in = !(t >= 3 && t <= 6);
      if (i < 8) begin
        valid_in  = 1'b1;
        data_a_in = 16'(i * 16'h2345);
        data_b_in = 16'(16'h1F0F ^ (i * 16'h0101));
        op_in     = 2'(i);
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk_in);
      acc = valid_in && ready_out;
      @(posedge clk_in) #1;
      if (acc) i++;
      t++;
    end
    check_value("bp_all_accepted", 32'(i), 32'd8);
    check_value("bp_drained", 32'(sb.size()), 32'd0);
    check_value("bp_saw_full", 32'(saw_full), 32'd1);

    // Reset with three ops in flight, the oldest already on the outputs
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in  = 1'b1;
      data_a_in = 16'(16'h1000 + k);
      data_b_in = 16'h0101;
      op_in     = 2'b00;
      @(posedge clk_in) #1;
    end
    valid_in = 1'b0;
    @(posedge clk_in) #1;
    check_value("pre_rst_valid", 32'(valid_out), 32'd1);
    rst_in = 1'b1;
    #1;
    check_value("mid_rst_valid", 32'(valid_out), 32'd0);
    check_value("mid_rst_data", 32'(data_out), 32'd0);
    @(posedge clk_in) #1;
    rst_in = 1'b0;
    send_op("post_rst", 16'h4000, 16'h3FFF, 2'b10, 16'h7FFF, 1'b0, 1'b0);
    cnt = 0;
    repeat (8) begin
      @(posedge clk_in) #1;
      if (valid_out) cnt++;
    end
    check_value("post_rst_alone", 32'(cnt), 32'd0);

    // Random traffic on both handshakes
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      valid_in  = ($urandom_range(0, 9) < 7);
      ready_in  = ($urandom_range(0, 9) < 7);
      data_a_in = rand_operand();
      data_b_in = rand_operand();
      op_in     = 2'($urandom_range(0, 3));
      @(negedge clk_in);
      if (valid_in && ready_out) n_acc++;
      @(posedge clk_in) #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      @(posedge clk_in) #1;
      cnt++;
    end
    check_value("rand_ops", 32'(n_acc), 32'd10000);
    check_value("rand_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
